// File: rtl/mem_port_arbiter_if.sv
// Memory control codes plus the requester-side bundle of the shared-port arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
package mem_port_arbiter_pkg;
  typedef enum logic {MEM_WR = 1'b0, NO_WR = 1'b1} wr_cond_code_t;
  typedef enum logic {MEM_RD = 1'b0, NO_RD = 1'b1} rd_cond_code_t;
endpackage

interface mem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic        cpu_lock;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_done;
  logic [15:0] cpu_rdata;

  logic        dma_req;
  logic        dma_wr;
  logic        dma_lock;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_done;
  logic [15:0] dma_rdata;

  modport master (
    output cpu_req, cpu_wr, cpu_lock, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  dma_gnt, dma_done, dma_rdata
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_lock, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    output dma_gnt, dma_done, dma_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/DMA arbiter for the single memorySystem port, with a bounded
// lock for back-to-back bursts. One ACCESS cycle per grant, then a RESP cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset_L,
  mem_port_arbiter_if.slave     req_bus,
  output logic [15:0]           mem_address,
  output wr_cond_code_t         mem_we_L,
  output rd_cond_code_t         mem_re_L,
  inout  wire  [15:0]           mem_data
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {CPU = 1'b0, DMA = 1'b1} who_t;

  state_t        state;
  who_t          owner;
  who_t          last;
  who_t          other;
  who_t          pick;
  logic          owner_wr;
  logic [CW-1:0] burst_cnt;

  logic          own_req, own_wr, own_lock, oth_req, oth_wr;
  logic [15:0]   own_addr, own_wdata;
  logic          drive_data;

  always_comb begin
    other     = (owner == CPU) ? DMA : CPU;
    own_req   = (owner == CPU) ? req_bus.cpu_req   : req_bus.dma_req;
    own_wr    = (owner == CPU) ? req_bus.cpu_wr    : req_bus.dma_wr;
    own_lock  = (owner == CPU) ? req_bus.cpu_lock  : req_bus.dma_lock;
    own_addr  = (owner == CPU) ? req_bus.cpu_addr  : req_bus.dma_addr;
    own_wdata = (owner == CPU) ? req_bus.cpu_wdata : req_bus.dma_wdata;
    oth_req   = (owner == CPU) ? req_bus.dma_req   : req_bus.cpu_req;
    oth_wr    = (owner == CPU) ? req_bus.dma_wr    : req_bus.cpu_wr;
    // Tie goes to whoever was not served last.
    if (req_bus.cpu_req && req_bus.dma_req) pick = (last == CPU) ? DMA : CPU;
    else if (req_bus.cpu_req)               pick = CPU;
    else                                    pick = DMA;
  end

  // Memory controls decode from state so an async reset releases them at once.
  always_comb begin
    drive_data  = (state == ACCESS) && owner_wr;
    mem_address = (state == ACCESS) ? own_addr : '0;
    mem_we_L    = drive_data ? MEM_WR : NO_WR;
    mem_re_L    = ((state == ACCESS) && !owner_wr) ? MEM_RD : NO_RD;
  end

  assign mem_data = drive_data ? own_wdata : 'z;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state             <= IDLE;
      owner             <= CPU;
      last              <= DMA;
      owner_wr          <= 1'b0;
      burst_cnt         <= '0;
      req_bus.cpu_gnt   <= 1'b0;
      req_bus.dma_gnt   <= 1'b0;
      req_bus.cpu_done  <= 1'b0;
      req_bus.dma_done  <= 1'b0;
      req_bus.cpu_rdata <= '0;
      req_bus.dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_bus.cpu_req || req_bus.dma_req) begin
            owner           <= pick;
            owner_wr        <= (pick == CPU) ? req_bus.cpu_wr : req_bus.dma_wr;
            burst_cnt       <= CW'(1);
            req_bus.cpu_gnt <= (pick == CPU);
            req_bus.dma_gnt <= (pick == DMA);
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (!owner_wr) begin
            if (owner == CPU) req_bus.cpu_rdata <= mem_data;
            else              req_bus.dma_rdata <= mem_data;
          end
          req_bus.cpu_done <= (owner == CPU);
          req_bus.dma_done <= (owner == DMA);
          state            <= RESP;
        end
        RESP: begin
          req_bus.cpu_done <= 1'b0;
          req_bus.dma_done <= 1'b0;
          last             <= owner;
          if (own_lock && own_req && (burst_cnt < CW'(MAX_BURST))) begin
            owner_wr  <= own_wr;
            burst_cnt <= burst_cnt + CW'(1);
            state     <= ACCESS;
          end else if (oth_req) begin
            owner           <= other;
            owner_wr        <= oth_wr;
            burst_cnt       <= CW'(1);
            req_bus.cpu_gnt <= (other == CPU);
            req_bus.dma_gnt <= (other == DMA);
            state           <= ACCESS;
          end else begin
            req_bus.cpu_gnt <= 1'b0;
            req_bus.dma_gnt <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a
// completion scoreboard (requester identity and captured read data).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic          clock = 1'b0;
  logic          reset_L;
  logic [15:0]   mem_address;
  wr_cond_code_t mem_we_L;
  rd_cond_code_t mem_re_L;
  wire  [15:0]   mem_data;

  logic          pre_en;
  logic [15:0]   pre_addr, pre_data;
  logic [15:0]   mem [0:65535];

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;

  typedef struct packed {
    logic        who;   // 0 = CPU, 1 = DMA
    logic        rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_BURST(4)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .req_bus     (bus.slave),
    .mem_address (mem_address),
    .mem_we_L    (mem_we_L),
    .mem_re_L    (mem_re_L),
    .mem_data    (mem_data)
  );

  always #5 clock = ~clock;

  assign mem_data = (mem_re_L == MEM_RD) ? mem[mem_address] : 'z;

  always @(posedge clock) begin
    if (pre_en)                 mem[pre_addr]    <= pre_data;
    else if (mem_we_L == MEM_WR) mem[mem_address] <= mem_data;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic c, input logic d);
    chk1({tag, "_cpu_gnt"}, bus.cpu_gnt, c);
    chk1({tag, "_dma_gnt"}, bus.dma_gnt, d);
  endtask

  task automatic expect_done(input logic who, input logic rd, input logic [15:0] data);
    exp_t e;
    e.who = who; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_done();
    exp_t e;
    if (bus.cpu_done || bus.dma_done) begin
      chk1("done_exclusive", bus.cpu_done & bus.dma_done, 1'b0);
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_done observed=cpu:%b/dma:%b expected=no_done",
               bus.cpu_done, bus.dma_done);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1("done_who", bus.dma_done, e.who);
        if (e.rd) chk16("done_rdata", e.who ? bus.dma_rdata : bus.cpu_rdata, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_gnt(tag, 1'b0, 1'b0);
    chk1({tag, "_cpu_done"}, bus.cpu_done, 1'b0);
    chk1({tag, "_dma_done"}, bus.dma_done, 1'b0);
    chk16({tag, "_cpu_rdata"}, bus.cpu_rdata, 16'h0000);
    chk16({tag, "_dma_rdata"}, bus.dma_rdata, 16'h0000);
    chk16({tag, "_addr"}, mem_address, 16'h0000);
    chk1({tag, "_we_idle"}, mem_we_L == NO_WR, 1'b1);
    chk1({tag, "_re_idle"}, mem_re_L == NO_RD, 1'b1);
  endtask

  initial begin
    reset_L = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_lock = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = '0; bus.dma_wdata = '0;
    repeat (2) tick();
    check_reset_outputs("reset");

    reset_L = 1'b1;
    pre_en = 1'b1; pre_addr = 16'h0100; pre_data = 16'hBEEF;
    tick();
    pre_addr = 16'h2000; pre_data = 16'h5A5A;
    tick();
    pre_en = 1'b0;
    tick();

    // Single CPU read
    bus.cpu_addr = 16'h0100; bus.cpu_wr = 1'b0; bus.cpu_req = 1'b1;
    expect_done(1'b0, 1'b1, 16'hBEEF);
    chk_gnt("t1_c0", 1'b0, 1'b0);
    tick();
    chk_gnt("t1_c1", 1'b1, 1'b0);
    chk1("t1_c1_re", mem_re_L == MEM_RD, 1'b1);
    chk1("t1_c1_we", mem_we_L == NO_WR, 1'b1);
    chk16("t1_c1_addr", mem_address, 16'h0100);
    tick();
    chk_gnt("t1_c2", 1'b1, 1'b0);
    chk1("t1_c2_done", bus.cpu_done, 1'b1);
    chk1("t1_c2_re", mem_re_L == MEM_RD, 1'b0);
    chk16("t1_dma_rdata", bus.dma_rdata, 16'h0000);
    bus.cpu_req = 1'b0;
    tick();
    chk_gnt("t1_c3", 1'b0, 1'b0);
    chk16("t1_c3_addr", mem_address, 16'h0000);

    // DMA write then CPU read back
    bus.dma_addr = 16'hFF10; bus.dma_wdata = 16'h1234; bus.dma_wr = 1'b1; bus.dma_req = 1'b1;
    expect_done(1'b1, 1'b0, 16'h0000);
    tick();
    chk_gnt("t2_c1", 1'b0, 1'b1);
    chk1("t2_c1_we", mem_we_L == MEM_WR, 1'b1);
    chk1("t2_c1_re", mem_re_L == NO_RD, 1'b1);
    chk16("t2_c1_addr", mem_address, 16'hFF10);
    chk16("t2_c1_data", mem_data, 16'h1234);
    tick();
    chk1("t2_c2_we", mem_we_L == NO_WR, 1'b1);
    chk16("t2_dma_rdata", bus.dma_rdata, 16'h0000);
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0;
    tick();
    bus.cpu_addr = 16'hFF10; bus.cpu_req = 1'b1;
    expect_done(1'b0, 1'b1, 16'h1234);
    tick();
    tick();
    bus.cpu_req = 1'b0;
    tick();

    // Simultaneous requests after reset alternate without idle gaps
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    bus.cpu_addr = 16'h0100; bus.dma_addr = 16'hFF10;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    expect_done(1'b0, 1'b1, 16'hBEEF);
    expect_done(1'b1, 1'b1, 16'h1234);
    expect_done(1'b0, 1'b1, 16'hBEEF);
    expect_done(1'b1, 1'b1, 16'h1234);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_gnt($sformatf("t3_c%0d", i), ((i - 1) / 2) % 2 == 0, ((i - 1) / 2) % 2 == 1);
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    tick();
    chk_gnt("t3_end", 1'b0, 1'b0);

    // CPU lock burst with DMA waiting: 4 CPU accesses, then DMA
    bus.cpu_lock = 1'b1; bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    for (int i = 0; i < 4; i++) expect_done(1'b0, 1'b1, 16'hBEEF);
    expect_done(1'b1, 1'b1, 16'h1234);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_gnt($sformatf("t4a_c%0d", i), i <= 8, i > 8);
      if (i == 8) begin bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0; end
      if (i == 10) bus.dma_req = 1'b0;
    end
    tick();
    chk_gnt("t4a_end", 1'b0, 1'b0);

    // CPU lock burst alone: re-granted after one IDLE cycle
    bus.cpu_lock = 1'b1; bus.cpu_req = 1'b1;
    for (int i = 0; i < 5; i++) expect_done(1'b0, 1'b1, 16'hBEEF);
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_gnt($sformatf("t4b_c%0d", i), i != 9, 1'b0);
    end
    bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0;
    tick();
    chk_gnt("t4b_end", 1'b0, 1'b0);

    // Reset during a DMA write ACCESS
    bus.dma_addr = 16'h2000; bus.dma_wdata = 16'hDEAD; bus.dma_wr = 1'b1; bus.dma_req = 1'b1;
    tick();
    chk_gnt("t5_c1", 1'b0, 1'b1);
    chk1("t5_c1_we", mem_we_L == MEM_WR, 1'b1);
    #2 reset_L = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0;
    tick();
    tick();
    chk16("t5_mem_kept", mem[16'h2000], 16'h5A5A);
    reset_L = 1'b1;
    bus.cpu_addr = 16'h2000; bus.cpu_req = 1'b1;
    expect_done(1'b0, 1'b1, 16'h5A5A);
    tick();
    chk_gnt("t5_cpu_c1", 1'b1, 1'b0);
    tick();
    bus.cpu_req = 1'b0;
    tick();

    // DMA request arriving during a CPU ACCESS is granted straight from RESP
    bus.cpu_addr = 16'h0100; bus.cpu_req = 1'b1;
    expect_done(1'b0, 1'b1, 16'hBEEF);
    tick();
    chk_gnt("t6_c1", 1'b1, 1'b0);
    bus.dma_addr = 16'hFF10; bus.dma_req = 1'b1;
    expect_done(1'b1, 1'b1, 16'h1234);
    tick();
    chk_gnt("t6_c2", 1'b1, 1'b0);
    bus.cpu_req = 1'b0;
    tick();
    chk_gnt("t6_c3", 1'b0, 1'b1);
    tick();
    bus.dma_req = 1'b0;
    tick();
    chk_gnt("t6_end", 1'b0, 1'b0);

    chk16("sb_empty", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
